// File: rtl/seg_display_scanner.sv
// seg_display_scanner: N-digit multiplexed seven-segment driver with hex/BCD modes, zero blanking, dp and blink
// Ports: clk, rst (async, active-high); value/load/dec_mode load a new value to show;
// blank_lz, dp_mask, blink_mask are live display controls; busy flags a decimal conversion;
// overflow flags a decimal value too large to show; display/dp/digit drive the active-low display.
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16,
  parameter int BLINK_SCANS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [6:0]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit
);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  localparam int CW = $clog2(VAL_W);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_SCANS - 1);
  localparam logic [CW-1:0] CLAST = CW'(VAL_W - 1);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction
  localparam logic [VAL_W-1:0] LIMIT = VAL_W'(pow10(NUM_DIGITS));
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [REFRESH_DIV-1:0] cnt;
  logic [IW-1:0]          idx;
  logic [BW-1:0]          bcnt;
  logic                   blink_on;
  logic [VAL_W-1:0]       shown, sreg, bcd, bcd_adj, bcd_nxt;
  logic [CW-1:0]          bit_cnt;
  logic                   ovf_pend;
  logic                   tick, wrap, hide, z;
  logic [NUM_DIGITS-1:0]  lz;
  logic [3:0]             nib;
  logic [6:0]             seg_n;
  logic                   dp_n;
  assign tick = &cnt;
  assign wrap = tick && idx == LAST;
  // one double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < NUM_DIGITS; k++)
      bcd_adj[4*k +: 4] = bcd[4*k +: 4] >= 4'd5 ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    bcd_nxt = {bcd_adj[VAL_W-2:0], sreg[VAL_W-1]};
  end
  // lz[k] is set when digit k and every more-significant digit are zero
  always_comb begin
    z  = 1'b1;
    lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z     = z & (shown[4*k +: 4] == 4'd0);
      lz[k] = z;
    end
  end
  assign nib   = shown[4*idx +: 4];
  assign hide  = blink_mask[idx] & ~blink_on;
  assign seg_n = hide ? 7'h7F :
                 overflow ? 7'b0111111 :
                 (blank_lz && idx != '0 && lz[idx]) ? 7'h7F : SEG[nib];
  assign dp_n  = hide | ~dp_mask[idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      blink_on <= 1'b1;
      shown    <= '0;
      sreg     <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      digit    <= '1;
      display  <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick) begin
        digit   <= ~(NUM_DIGITS'(1) << idx);
        display <= seg_n;
        dp      <= dp_n;
        idx     <= idx == LAST ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        bcnt <= bcnt == BLAST ? '0 : bcnt + 1'b1;
        if (bcnt == BLAST) blink_on <= ~blink_on;
      end
      if (busy) begin
        sreg    <= {sreg[VAL_W-2:0], 1'b0};
        bcd     <= bcd_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == CLAST) begin
          shown    <= bcd_nxt;
          overflow <= ovf_pend;
          busy     <= 1'b0;
        end
      end else if (load) begin
        if (dec_mode) begin
          sreg     <= value;
          bcd      <= '0;
          bit_cnt  <= '0;
          ovf_pend <= value >= LIMIT;
          busy     <= 1'b1;
        end else begin
          shown    <= value;
          overflow <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner: directed self-checking bench for seg_display_scanner
module tb_seg_display_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0, dec_mode = 1'b0, blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0, blink_mask = '0;
  logic        busy, overflow, dp;
  logic [6:0]  display;
  logic [3:0]  digit;
  int n_vec = 0, n_bad = 0;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  always #5 clk = ~clk;
  seg_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(3), .BLINK_SCANS(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dec_mode(dec_mode),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .busy(busy), .overflow(overflow), .display(display), .dp(dp), .digit(digit)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  task automatic load_val(input logic [15:0] v, input logic dm);
    value = v;
    dec_mode = dm;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask
  task automatic wait_digit(input int i);
    logic [3:0] t;
    int n;
    t = ~(4'b0001 << i);
    n = 0;
    while (digit == t && n < 80) begin step(1); n++; end
    while (digit != t && n < 80) begin step(1); n++; end
    check($sformatf("digit%0d_reached", i), digit, t);
  endtask
  task automatic show(input string tag, input int i, input logic [6:0] seg, input logic dpv);
    wait_digit(i);
    check($sformatf("%s_d%0d_seg", tag, i), display, seg);
    check($sformatf("%s_d%0d_dp", tag, i), dp, dpv);
  endtask
  initial begin
    logic [3:0]  ring [4];
    logic [6:0]  hex_exp [4];
    logic [6:0]  dec_exp [4];
    logic [15:0] bee;
    int cyc, lit;
    ring = '{4'hD, 4'hB, 4'h7, 4'hE};
    hex_exp = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
    dec_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bee = 16'hBEEF;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_digit", digit, 4'hF);
    check("rst_display", display, 7'h7F);
    check("rst_dp", dp, 1);
    step(7);
    check("pre_tick_digit", digit, 4'hF);
    step(1);
    check("tick1_digit", digit, 4'hE);
    check("tick1_display", display, 7'b1000000);
    for (int k = 0; k < 4; k++) begin
      step(8);
      check($sformatf("scan%0d_digit", k), digit, ring[k]);
      check($sformatf("scan%0d_display", k), display, 7'b1000000);
    end
    load_val(16'hBEEF, 1'b0);
    check("hex_busy0", busy, 0);
    step(3);
    check("hex_busy1", busy, 0);
    for (int i = 0; i < 4; i++) show("hex", i, hex_exp[i], 1'b1);
    load_val(16'd1234, 1'b1);
    cyc = 0;
    while (busy && cyc < 40) begin cyc++; step(1); end
    check("dec_busy_cycles", cyc, 16);
    lit = 0;
    for (int k = 0; k < 4; k++) if (!digit[k]) lit = k;
    check("dec_hold_old", display, SEG_TAB[bee[4*lit +: 4]]);
    check("dec_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) show("dec", i, dec_exp[i], 1'b1);
    load_val(16'd12000, 1'b1);
    step(15);
    check("ovf_busy_e16", busy, 1);
    check("ovf_pre", overflow, 0);
    step(1);
    check("ovf_busy_e17", busy, 0);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < 4; i++) show("ovf", i, 7'b0111111, 1'b1);
    blank_lz = 1'b1;
    load_val(16'd7, 1'b1);
    step(16);
    check("lz_busy", busy, 0);
    check("lz_ovf", overflow, 0);
    show("lz", 0, 7'b1111000, 1'b1);
    for (int i = 1; i < 4; i++) show("lz", i, 7'h7F, 1'b1);
    blank_lz = 1'b0;
    load_val(16'd5555, 1'b1);
    step(1);
    value = 16'd9;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(13);
    check("ign_busy_e16", busy, 1);
    step(1);
    check("ign_busy_e17", busy, 0);
    for (int i = 0; i < 4; i++) show("ign", i, 7'b0010010, 1'b1);
    blink_mask = 4'b0001;
    dp_mask = 4'b0010;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      show($sformatf("blink_r%0d", r), 0, ((r / 2) % 2 == 0) ? 7'b1000000 : 7'h7F, 1'b1);
      show($sformatf("blink_r%0d", r), 1, 7'b1000000, 1'b0);
    end
    blink_mask = '0;
    dp_mask = '0;
    load_val(16'd9999, 1'b1);
    step(7);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_digit", digit, 4'hF);
    check("mid_rst_display", display, 7'h7F);
    check("mid_rst_dp", dp, 1);
    step(1);
    rst = 1'b0;
    show("mid", 0, 7'b1000000, 1'b1);
    show("mid", 1, 7'b1000000, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
